// File: rtl/super_register_sequencer.sv
// Command sequencer for an 8-bit super register: applies one operation for a
// requested number of cycles (optionally stopping on the register flag), then reports the outcome.
module super_register_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic             cmd_stop_on_flag,
  output logic [2:0]       reg_operation,
  output logic [7:0]       reg_in_data,
  output logic             reg_in_shift_right,
  output logic             reg_in_shift_left,
  input  logic [7:0]       reg_out_data,
  input  logic             reg_flag,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic [CNT_W-1:0] steps,
  output logic             early_stop
);

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       op_reg;
  logic [7:0]       data_reg;
  logic             fill_reg;
  logic             stop_en_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] step_reg, step_next;
  logic             cause_reg, cause_next;
  logic             done_reg;
  logic [7:0]       result_reg;
  logic [CNT_W-1:0] steps_reg;
  logic             early_reg;
  logic             accept;
  logic [CNT_W-1:0] eff_count;

  // A load always applies exactly once, whatever count the host supplied.
  assign eff_count = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;

  always_comb begin
    state_next         = state_reg;
    step_next          = step_reg;
    cause_next         = cause_reg;
    accept             = 1'b0;
    cmd_ready          = 1'b0;
    busy               = 1'b0;
    reg_operation      = OP_STORE;
    reg_in_data        = 8'h00;
    reg_in_shift_right = 1'b0;
    reg_in_shift_left  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          step_next  = '0;
          cause_next = 1'b0;
          state_next = (eff_count == '0) ? CAPT : EXEC;
        end
      end
      EXEC: begin
        busy = 1'b1;
        // Flag only counts once at least one step has run, so a start value of 00/FF is not a stop.
        if (stop_en_reg && reg_flag && (step_reg != '0)) begin
          cause_next = 1'b1;
          state_next = CAPT;
        end else begin
          reg_operation      = op_reg;
          reg_in_data        = data_reg;
          reg_in_shift_right = fill_reg;
          reg_in_shift_left  = fill_reg;
          step_next          = step_reg + CNT_W'(1);
          if (step_next == count_reg) state_next = CAPT;
        end
      end
      CAPT: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Clear the register on the same edge that resets the controller.
    if (!rst_n) begin
      reg_operation      = OP_LOAD;
      reg_in_data        = 8'h00;
      reg_in_shift_right = 1'b0;
      reg_in_shift_left  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      op_reg      <= OP_STORE;
      data_reg    <= 8'h00;
      fill_reg    <= 1'b0;
      stop_en_reg <= 1'b0;
      count_reg   <= '0;
      step_reg    <= '0;
      cause_reg   <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= 8'h00;
      steps_reg   <= '0;
      early_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      cause_reg <= cause_next;
      done_reg  <= (state_reg == CAPT);
      if (accept) begin
        op_reg      <= cmd_op;
        data_reg    <= cmd_data;
        fill_reg    <= cmd_fill;
        stop_en_reg <= cmd_stop_on_flag;
        count_reg   <= eff_count;
      end
      if (state_reg == CAPT) begin
        result_reg <= reg_out_data;
        steps_reg  <= step_reg;
        early_reg  <= cause_reg;
      end
    end
  end

  assign done       = done_reg;
  assign result     = result_reg;
  assign steps      = steps_reg;
  assign early_stop = early_reg;

endmodule

// File: doc/super_register_sequencer.md
Name: super_register_sequencer

Overview:
- Command-driven controller that owns the `operation`, `in_data` and shift-in inputs of one 8-bit super register.
- Accepts one command per handshake: an operation, a repeat count, fill bit and optional early stop on the register's flag.
- Issues that operation for the requested number of cycles, then returns the register value, step count and stop cause.
- Sits between a host or control FSM and the register so the host never drives `operation` cycle by cycle.

Parameters:
CNT_W, 4, width of repeat count and step counter (max count 2^CNT_W-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept; high only in IDLE
cmd_op  input  3  register operation code: 0 load, 1 shr, 2 shl, 3 ror, 4 rol, 5 store, 6 up, 7 down
cmd_data  input  8  load value (used only when cmd_op=0)
cmd_count  input  CNT_W  number of cycles to apply cmd_op
cmd_fill  input  1  bit shifted in for shr/shl
cmd_stop_on_flag  input  1  terminate early when register flag is high
reg_operation  output  3  to register operation input
reg_in_data  output  8  to register in_data
reg_in_shift_right  output  1  to register in_shift_right
reg_in_shift_left  output  1  to register in_shift_left
reg_out_data  input  8  from register out_data
reg_flag  input  1  from register flag (all zeros or all ones)
busy  output  1  high in EXEC and CAPT
done  output  1  one-cycle pulse, result fields valid
result  output  8  register value at command end
steps  output  CNT_W  operations actually applied
early_stop  output  1  command ended due to flag

Behaviour:
Reset:
- While rst_n=0 at a clock edge: state<=IDLE, done<=0, result<=0, steps<=0, early_stop<=0, internal step counter<=0.
- While rst_n=0, reg_operation=0 (load) with reg_in_data=0, so the register clears on the same edge.
- Reset mid-command aborts it with no done pulse.

IDLE:
- cmd_ready=1; reg_operation=5 (store); reg_in_data=0; shift-ins=0.
- Accept on cmd_valid & cmd_ready at an edge: latch op, data, fill, stop_on_flag; effective count = 1 if op=0, else cmd_count.
- Clear step counter on accept.
- Go to EXEC if effective count>0, else CAPT.
- Store with count>0 runs normally (register holds).
- cmd_valid while not IDLE is ignored (ready=0); the host must hold it.

EXEC:
- If stop_on_flag & reg_flag & step_counter!=0: drive store, set early_stop flag, go CAPT.
  - Flag is checked only after at least one step, so an initial 0x00/0xFF does not stop.
- Otherwise drive latched op; reg_in_data = latched data; both shift-ins = latched fill; step_counter+1.
- If the incremented step_counter = effective count, go CAPT.
- Register wrap-around (0xFF+1=0x00, 0x00-1=0xFF) is the register's behaviour; the controller does not detect it.

CAPT:
- Drive store for one cycle.
- At the edge: result<=reg_out_data, steps<=step_counter, early_stop<=stop cause, done<=1, state<=IDLE.
- done clears after one cycle.
- result, steps and early_stop hold until the next CAPT or reset.
- A new command may be accepted in the cycle done is high.

Timing and outputs:
- Latency from accept edge to done high:
  - N+2 cycles for N steps without early stop (N EXEC cycles + CAPT).
  - k+3 cycles when stopping after k steps.
  - 2 cycles for count 0.
- reg_* outputs are combinational from state and latched command; all status outputs are registered.

Test Plan:
- Load 0x5A (count ignored, =9) -> done 3 cycles after accept; result=0x5A, steps=1, early_stop=0.
- Register 0x81, rol count 3 -> result=0x0C, steps=3, done at accept+5; reg_operation=4 for exactly 3 cycles.
- Register 0xFB, up count 10, stop_on_flag=1 -> stops at 0xFF; result=0xFF, steps=4, early_stop=1; one store cycle before CAPT.
- Register 0x00, shr count 8, fill=1, stop_on_flag=1 -> initial flag does not stop; ends at 0xFF after 8 steps, early_stop=0.
- Count 0, op up, register 0x33 -> done at accept+2, result=0x33, steps=0; cmd_valid held during busy not accepted until IDLE.
- rst_n=0 during EXEC of down count 10 -> next cycle IDLE, cmd_ready=1, register reads 0x00, no done pulse.
